// File: rtl/clk_cfg_seq.sv
// Clock configuration sequencer for rst_clk_ctrl.
// Applies a requested clock setup in glitch-safe order.
module clk_cfg_seq #(
    parameter int SETTLE   = 16,
    parameter int PLL_WAIT = 256,
    parameter int CW       = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_src,
    input  logic [1:0] req_div,
    input  logic [1:0] req_rosc,
    input  logic [1:0] req_trim,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       pll_en,
    output logic [1:0] pll_trim,
    output logic       sel_8mhz,
    output logic       sel_pll,
    output logic [1:0] sel_rosc,
    output logic [1:0] clk_div
);

    typedef enum logic [2:0] {
        IDLE,
        DIVMAX,
        PARK,
        PLLON,
        INNER,
        OUTER,
        FINDIV
    } state_t;

    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] PLL_LD    = CW'(PLL_WAIT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    src_q;
    logic [1:0]    div_q;
    logic [1:0]    rosc_q;
    logic [1:0]    trim_q;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Sequencer: each step updates its outputs on entry, then holds for its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            src_q    <= 2'd0;
            div_q    <= 2'd0;
            rosc_q   <= 2'd0;
            trim_q   <= 2'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            pll_en   <= 1'b0;
            pll_trim <= 2'd0;
            sel_8mhz <= 1'b1;
            sel_pll  <= 1'b0;
            sel_rosc <= 2'd0;
            clk_div  <= 2'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_src == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            src_q   <= req_src;
                            div_q   <= req_div;
                            rosc_q  <= req_rosc;
                            trim_q  <= req_trim;
                            clk_div <= 2'd3;
                            cnt     <= SETTLE_LD;
                            state   <= DIVMAX;
                        end
                    end
                end
                DIVMAX: begin
                    if (cnt == '0) begin
                        sel_8mhz <= 1'b1;
                        cnt      <= SETTLE_LD;
                        state    <= PARK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PARK: begin
                    if (cnt == '0) begin
                        if (src_q == 2'd1 &&
                            (!pll_en || pll_trim != trim_q)) begin
                            pll_trim <= trim_q;
                            pll_en   <= 1'b1;
                            cnt      <= PLL_LD;
                            state    <= PLLON;
                        end else begin
                            sel_pll  <= (src_q == 2'd1);
                            sel_rosc <= rosc_q;
                            cnt      <= SETTLE_LD;
                            state    <= INNER;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PLLON: begin
                    if (cnt == '0) begin
                        sel_pll  <= (src_q == 2'd1);
                        sel_rosc <= rosc_q;
                        cnt      <= SETTLE_LD;
                        state    <= INNER;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                INNER: begin
                    if (cnt == '0) begin
                        sel_8mhz <= (src_q == 2'd0);
                        cnt      <= SETTLE_LD;
                        state    <= OUTER;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                OUTER: begin
                    if (cnt == '0) begin
                        clk_div <= div_q;
                        cnt     <= SETTLE_LD;
                        state   <= FINDIV;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FINDIV: begin
                    if (cnt == '0) begin
                        if (src_q != 2'd1) pll_en <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/clk_cfg_seq.md
Name: clk_cfg_seq

Overview:
- Sequencer that drives the configuration inputs of rst_clk_ctrl: pll_en, pll_trim, sel_8mhz, sel_pll, sel_rosc and clk_div.
- Software or a boot FSM requests a target clock configuration through a valid/ready handshake.
- The block applies the request in a glitch-safe order: maximum divide first, park on the reference clock, start the PLL and wait for it, switch the inner mux, switch the outer mux, then set the final divider.
- It runs on the system clock and reset produced by rst_clk_ctrl.

Parameters:
- SETTLE, 16: cycles each mux/divider step is held before the next step (>=2).
- PLL_WAIT, 256: cycles allowed for PLL start-up after pll_en rises (>=2).
- CW, 10: width of the internal wait counter; must satisfy 2^CW > max(SETTLE, PLL_WAIT).

Ports:
- clk  in  1  System clock (output of rst_clk_ctrl).
- rst_n  in  1  Asynchronous active-low reset.
- req_valid  in  1  A request is presented.
- req_ready  out  1  Block is idle and can accept a request.
- req_src  in  2  Target source: 0=8 MHz ref, 1=PLL, 2=ROSC, 3=invalid.
- req_div  in  2  Target clk_div.
- req_rosc  in  2  Target sel_rosc.
- req_trim  in  2  Target pll_trim (used only when req_src=1).
- busy  out  1  Sequence in progress.
- done  out  1  One-cycle pulse when a sequence completes.
- err  out  1  One-cycle pulse when a request with req_src=3 is rejected.
- pll_en  out  1  To rst_clk_ctrl.
- pll_trim  out  2  To rst_clk_ctrl.
- sel_8mhz  out  1  To rst_clk_ctrl.
- sel_pll  out  1  To rst_clk_ctrl.
- sel_rosc  out  2  To rst_clk_ctrl.
- clk_div  out  2  To rst_clk_ctrl.

Behaviour:
- Reset values (asynchronous):
  - pll_en=0, pll_trim=0, sel_8mhz=1, sel_pll=0, sel_rosc=0, clk_div=0.
  - req_ready=1, busy=0, done=0, err=0, state=IDLE.
- Handshake:
  - A request is accepted on a rising edge with req_valid & req_ready.
  - req_src, req_div, req_rosc and req_trim are latched on that edge; later changes are ignored until the next acceptance.
  - req_ready = (state==IDLE); busy = !req_ready.
- req_src=3: accepted, err pulses the cycle after acceptance, state stays IDLE, no output changes.
- States (each step's outputs update on the entry edge; the step then lasts its full count before the next transition):
  - IDLE: waits for a request.
  - DIVMAX: clk_div<=3; lasts SETTLE cycles.
  - PARK: sel_8mhz<=1; lasts SETTLE cycles.
  - PLLON: entered only if target=PLL and (pll_en==0 or pll_trim != latched trim). On entry pll_trim<=trim and pll_en<=1; lasts PLL_WAIT cycles. Otherwise skipped.
  - INNER: sel_pll<=(src==1); sel_rosc<=latched rosc; lasts SETTLE cycles.
  - OUTER: sel_8mhz<=(src==0); lasts SETTLE cycles.
  - FINDIV: clk_div<=latched div; lasts SETTLE cycles. On exit, if src!=1 then pll_en<=0. Go to IDLE with a done pulse in the first IDLE cycle.
- Retrimming: when the PLL is already running and the trim changes, pll_en is not toggled; only pll_trim is updated in PLLON.
- Latency: acceptance edge to done = 5*SETTLE (+PLL_WAIT when PLLON is taken) cycles.
- Counter: loaded with N-1 on state entry, decremented every cycle, transition when it reaches 0. No wrap occurs.
- Back-to-back requests: a new request may be accepted in the same cycle done is high.
- Reset mid-sequence: all outputs return immediately to their reset values and any latched request is discarded.
- An identical repeated request still runs the full sequence (minus PLLON if the PLL is already on with the same trim).

Test Plan (SETTLE=4, PLL_WAIT=20):
- Reset -> all outputs at reset values, req_ready=1; xrst_n pulse of ~1-5 us mid-run restores the same values.
- From reset, request src=1, div=1, trim=2 -> clk_div=3 for 4 cycles, sel_8mhz=1, pll_en=1 & pll_trim=2 held 20 cycles, sel_pll=1, sel_8mhz=0, clk_div=1; done exactly 40 cycles after acceptance.
- Then request src=2, rosc=3, div=3 -> PLLON skipped; sel_pll=0, sel_rosc=3, sel_8mhz=0, clk_div=3; pll_en falls with done; done 20 cycles after acceptance.
- Request src=3 -> err pulse, no output change, req_ready stays 1.
- Assert rst_n at the 10th PLLON cycle -> all outputs at reset values on the same edge, busy=0; a subsequent src=0 request completes in 20 cycles.
- Hold req_valid high with a second request during busy -> not accepted until done. Checker confirms sel_8mhz=1 whenever sel_pll or sel_rosc changes.
